// File: rtl/sm_icache.sv
// Direct-mapped read-only instruction cache between fetch and instruction ROM.
// Optional hit/miss statistics counters are enabled by defining SM_ICACHE_STATS_EN.
//
// state  | meaning
// IDLE   | lookups served combinationally; a miss starts a line refill
// REFILL | fetching words 0..LINE_WORDS-1 of the missed line from the ROM port
module sm_icache #(
  parameter int LINES      = 8,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic [31:0] cpu_addr,
  output logic        cpu_ready,
  output logic [31:0] cpu_rdata,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
`ifdef SM_ICACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int OFF  = $clog2(LINE_WORDS);
  localparam int IDX  = $clog2(LINES);
  localparam int TAGW = 32 - OFF - IDX;
  localparam logic [OFF-1:0] LAST = OFF'(LINE_WORDS - 1);

  typedef enum logic {IDLE, REFILL} state_t;

  state_t state_q, state_d;

  logic [LINES-1:0] valid_q;
  logic [TAGW-1:0]  tag_mem  [LINES];
  logic [31:0]      data_mem [LINES][LINE_WORDS];

  logic [TAGW-1:0] rtag_q;
  logic [IDX-1:0]  ridx_q;
  logic [OFF-1:0]  cnt_q;

  logic [OFF-1:0]  cpu_off;
  logic [IDX-1:0]  cpu_idx;
  logic [TAGW-1:0] cpu_tag;
  logic            hit;
  logic            start;
  logic            fill;
  logic            done;

  assign cpu_off = cpu_addr[OFF-1:0];
  assign cpu_idx = cpu_addr[OFF+IDX-1:OFF];
  assign cpu_tag = cpu_addr[31:OFF+IDX];

  assign hit = cpu_req && (state_q == IDLE) && valid_q[cpu_idx] &&
               (tag_mem[cpu_idx] == cpu_tag);

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    fill    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_req && !hit && !flush) begin
          start   = 1'b1;
          state_d = REFILL;
        end
      end
      REFILL: begin
        // flush aborts the refill; the partial line is never marked valid
        if (flush) begin
          state_d = IDLE;
        end else if (mem_ack) begin
          fill = 1'b1;
          if (cnt_q == LAST) begin
            done    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cpu_ready = hit;
  assign cpu_rdata = hit ? data_mem[cpu_idx][cpu_off] : 32'd0;
  assign mem_req   = (state_q == REFILL);
  assign mem_addr  = mem_req ? {rtag_q, ridx_q, cnt_q} : 32'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      valid_q <= '0;
      rtag_q  <= '0;
      ridx_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (flush) begin
        valid_q <= '0;
      end else if (start) begin
        valid_q[cpu_idx] <= 1'b0;
      end else if (done) begin
        valid_q[ridx_q] <= 1'b1;
      end
      if (start) begin
        rtag_q <= cpu_tag;
        ridx_q <= cpu_idx;
      end
      if (start || flush) begin
        cnt_q <= '0;
      end else if (fill) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // tag and data arrays carry no reset; valid_q guards every use
  always_ff @(posedge clk) begin
    if (fill) begin
      data_mem[ridx_q][cnt_q] <= mem_rdata;
    end
    if (done) begin
      tag_mem[ridx_q] <= rtag_q;
    end
  end

`ifdef SM_ICACHE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= 32'd0;
      miss_cnt <= 32'd0;
    end else begin
      if (hit) begin
        hit_cnt <= hit_cnt + 32'd1;
      end
      if (start) begin
        miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sm_icache.sv
// Bench for sm_icache: line-level cache model checked every negedge plus directed literal checks.
module tb_sm_icache;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req = 1'b0;
  logic [31:0] cpu_addr = 32'd0;
  logic        flush = 1'b0;
  logic        mem_ack = 1'b0;
  logic        cpu_ready;
  logic [31:0] cpu_rdata;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
`ifdef SM_ICACHE_STATS_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  int total = 0;
  int bad   = 0;

  sm_icache #(.LINES(8), .LINE_WORDS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_req   (cpu_req),
    .cpu_addr  (cpu_addr),
    .cpu_ready (cpu_ready),
    .cpu_rdata (cpu_rdata),
    .flush     (flush),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
`ifdef SM_ICACHE_STATS_EN
    ,
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  assign mem_rdata = 32'h1000 + mem_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Model: which memory line (addr>>2) each set holds, and the line being fetched.
  bit          m_busy;
  int unsigned m_line;
  int unsigned m_k;
  bit          m_val [8];
  int unsigned m_held [8];
  int unsigned m_hits;
  int unsigned m_miss;

  always @(negedge clk) begin
    bit          h;
    int unsigned ln;
    int unsigned ix;
    ln = cpu_addr >> 2;
    ix = ln % 8;
    if (!rst_n) begin
      chk("rst ready", {31'd0, cpu_ready}, 32'd0);
      chk("rst rdata", cpu_rdata, 32'd0);
      chk("rst mem_req", {31'd0, mem_req}, 32'd0);
      chk("rst mem_addr", mem_addr, 32'd0);
      m_busy = 0;
      m_k    = 0;
      m_hits = 0;
      m_miss = 0;
      for (int i = 0; i < 8; i++) m_val[i] = 0;
    end else begin
      h = cpu_req && !m_busy && m_val[ix] && (m_held[ix] == ln);
      chk("ready", {31'd0, cpu_ready}, {31'd0, h});
      chk("rdata", cpu_rdata, h ? 32'h1000 + cpu_addr : 32'd0);
      chk("mem_req", {31'd0, mem_req}, {31'd0, m_busy});
      chk("mem_addr", mem_addr, m_busy ? m_line * 4 + m_k : 32'd0);
`ifdef SM_ICACHE_STATS_EN
      chk("hit_cnt", hit_cnt, m_hits);
      chk("miss_cnt", miss_cnt, m_miss);
`endif
      if (h) m_hits++;
      if (flush) begin
        m_busy = 0;
        for (int i = 0; i < 8; i++) m_val[i] = 0;
      end else if (m_busy) begin
        if (mem_ack) begin
          m_k++;
          if (m_k == 4) begin
            m_busy = 0;
            m_val[m_line % 8]  = 1;
            m_held[m_line % 8] = m_line;
          end
        end
      end else if (cpu_req && !h) begin
        m_busy = 1;
        m_line = ln;
        m_k    = 0;
        m_val[ix] = 0;
        m_miss++;
      end
    end
  end

  task automatic cyc(input bit req, input logic [31:0] a, input bit fl, input bit ack);
    @(posedge clk);
    #1;
    cpu_req  = req;
    cpu_addr = a;
    flush    = fl;
    mem_ack  = ack;
  endtask

  task automatic fill_line(input logic [31:0] a);
    bit got;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      cyc(1, a, 0, 1);
      #5;
      if (cpu_ready) got = 1;
    end
    chk("fill timeout", {31'd0, got}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit ack;
    @(posedge clk);
    #1;
    chk("reset ready", {31'd0, cpu_ready}, 32'd0);
    chk("reset mem_req", {31'd0, mem_req}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // cold miss at address 0
    cyc(1, 0, 0, 1); #5;
    chk("cold miss ready", {31'd0, cpu_ready}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 0, 1); #5;
      chk("cold mem_req", {31'd0, mem_req}, 32'd1);
      chk("cold mem_addr", mem_addr, i);
    end
    cyc(1, 0, 0, 1); #5;
    chk("cold hit ready", {31'd0, cpu_ready}, 32'd1);
    chk("cold hit data", cpu_rdata, 32'h1000);

    for (int a = 1; a < 4; a++) begin
      cyc(1, a, 0, 1); #5;
      chk("seq ready", {31'd0, cpu_ready}, 32'd1);
      chk("seq data", cpu_rdata, 32'h1000 + a);
      chk("seq mem_req", {31'd0, mem_req}, 32'd0);
    end

    // conflict eviction of set 0
    fill_line(32);
    chk("conflict data", cpu_rdata, 32'h1020);
    cyc(0, 0, 0, 1); #5;
`ifdef SM_ICACHE_STATS_EN
    chk("stats hits", hit_cnt, 32'd5);
    chk("stats misses", miss_cnt, 32'd2);
`endif
    cyc(1, 0, 0, 1); #5;
    chk("evicted ready", {31'd0, cpu_ready}, 32'd0);
    fill_line(0);

    // backpressure on refill of address 8
    cyc(1, 8, 0, 1);
    ack = 1;
    n = 0;
    for (int i = 0; i < 16; i++) begin
      ack = ~ack;
      cyc(1, 8, 0, ack); #5;
      if (!mem_req) break;
      n++;
    end
    chk("bp refill cycles", n, 32'd8);
    chk("bp data 8", cpu_rdata, 32'h1008);
    for (int a = 9; a < 12; a++) begin
      cyc(1, a, 0, 1); #5;
    end
    chk("bp data 11", cpu_rdata, 32'h100B);

    // flush in refill cycle 2
    cyc(1, 16, 0, 1);
    cyc(1, 16, 0, 1);
    cyc(1, 16, 1, 1);
    cyc(1, 16, 0, 1); #5;
    chk("flush idle mem_req", {31'd0, mem_req}, 32'd0);
    chk("flush no stale hit", {31'd0, cpu_ready}, 32'd0);
    fill_line(16);
    cyc(1, 0, 0, 1); #5;
    chk("flushed line0", {31'd0, cpu_ready}, 32'd0);
    fill_line(0);

    // async reset mid-refill
    cyc(1, 24, 0, 1);
    cyc(1, 24, 0, 1);
    cyc(1, 24, 0, 1);
    #2;
    chk("pre-reset mem_req", {31'd0, mem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async rst mem_req", {31'd0, mem_req}, 32'd0);
    chk("async rst mem_addr", mem_addr, 32'd0);
    chk("async rst ready", {31'd0, cpu_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    cpu_req  = 1'b1;
    cpu_addr = 32'd8;
    #5;
    chk("post-reset miss", {31'd0, cpu_ready}, 32'd0);
    fill_line(8);
    chk("post-reset data", cpu_rdata, 32'h1008);

    cyc(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
